// File: rtl/output_ctrl_if.sv
// Flit interface between the crossbar/link environment and output_ctrl.
//   inner_dataI / inner_wr_en : flit written from the crossbar
//   receiveO                  : downstream ready
//   sig_channel_clean         : internally owned VC buffer is empty
//   sendO / dataO             : link valid and flit
//   polarity                  : 1 in ODD phase
//   drop_err                  : sticky write-into-full-buffer flag
interface output_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 64
);
  logic [DATA_WIDTH-1:0] inner_dataI;
  logic                  inner_wr_en;
  logic                  receiveO;
  logic                  sig_channel_clean;
  logic                  sendO;
  logic [DATA_WIDTH-1:0] dataO;
  logic                  polarity;
  logic                  drop_err;

  // Environment side: drives crossbar writes and downstream ready.
  modport master (
    output inner_dataI, inner_wr_en, receiveO,
    input  sig_channel_clean, sendO, dataO, polarity, drop_err
  );

  // Controller side.
  modport slave (
    input  inner_dataI, inner_wr_en, receiveO,
    output sig_channel_clean, sendO, dataO, polarity, drop_err
  );
endinterface

// File: rtl/output_ctrl.sv
// Router output-port controller. Two single-entry virtual-channel buffers
// (odd/even) alternate ownership between the crossbar side and the link side
// every cycle; the link side sends its buffer when downstream is ready.
// Ports:
//   clk  - clock, all state on posedge
//   rst  - synchronous active-high reset
//   bus  - output_ctrl_if.slave (crossbar write, link send, status)
module output_ctrl #(
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic          clk,
  input  logic          rst,
  output_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ODD  = 2'd1,
    ST_EVEN = 2'd2
  } state_t;

  // Buffer index 1 is the odd VC, index 0 the even VC.
  localparam logic IDX_ODD  = 1'b1;
  localparam logic IDX_EVEN = 1'b0;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_buf_data [2];
  logic [1:0]            r_buf_valid;
  logic                  r_drop_err;

  logic                  w_active;
  logic                  w_int_idx;
  logic                  w_link_idx;
  logic                  w_clean;
  logic                  w_send;
  logic [DATA_WIDTH-1:0] w_data_out;
  logic                  w_wr_accept;
  logic                  w_wr_drop;

  // Phase register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next phase, buffer ownership and link/write decisions.
  always_comb begin
    w_state_nxt = ST_IDLE;
    w_active    = 1'b0;
    w_int_idx   = IDX_EVEN;
    w_link_idx  = IDX_ODD;
    w_clean     = 1'b0;
    w_send      = 1'b0;
    w_data_out  = '0;
    w_wr_accept = 1'b0;
    w_wr_drop   = 1'b0;

    case (r_state)
      ST_IDLE: w_state_nxt = ST_ODD;
      ST_ODD: begin
        w_state_nxt = ST_EVEN;
        w_active    = 1'b1;
        w_int_idx   = IDX_ODD;
        w_link_idx  = IDX_EVEN;
      end
      ST_EVEN: begin
        w_state_nxt = ST_ODD;
        w_active    = 1'b1;
        w_int_idx   = IDX_EVEN;
        w_link_idx  = IDX_ODD;
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if (w_active) begin
      w_clean     = ~r_buf_valid[w_int_idx];
      w_send      = r_buf_valid[w_link_idx] & bus.receiveO;
      w_wr_accept = bus.inner_wr_en & ~r_buf_valid[w_int_idx];
      w_wr_drop   = bus.inner_wr_en &  r_buf_valid[w_int_idx];
    end
    if (w_send) w_data_out = r_buf_data[w_link_idx];
  end

  // VC buffers and sticky drop flag; write and send never hit the same buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf_valid   <= 2'b00;
      r_buf_data[0] <= '0;
      r_buf_data[1] <= '0;
      r_drop_err    <= 1'b0;
    end else begin
      if (w_send) r_buf_valid[w_link_idx] <= 1'b0;
      if (w_wr_accept) begin
        r_buf_valid[w_int_idx] <= 1'b1;
        r_buf_data[w_int_idx]  <= bus.inner_dataI;
      end
      if (w_wr_drop) r_drop_err <= 1'b1;
    end
  end

  assign bus.sig_channel_clean = w_clean;
  assign bus.sendO             = w_send;
  assign bus.dataO             = w_data_out;
  assign bus.polarity          = (r_state == ST_ODD);
  assign bus.drop_err          = r_drop_err;

endmodule
